// File: rtl/hdc_main.sv
// HDC spam/ham classifier: item memory, trigram binding, majority bundling,
// Hamming-distance compare against two class prototypes.
module hdc_main #(
    parameter int             D       = 256,
    parameter int             MSG_LEN = 200,
    parameter int             CHAR_W  = 8,
    parameter logic [D-1:0]   BASE_HV = {8{32'hA5C3_9E17}},
    parameter logic [D-1:0]   HAM_HV  = {D{1'b0}},
    parameter logic [D-1:0]   SPAM_HV = {D{1'b1}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [MSG_LEN*CHAR_W-1:0] msg,
    input  logic [7:0]                length,
    input  logic [1:0]                label,
    output logic [1:0]                result,
    output logic                      valid
);
    localparam int CW = $clog2(D + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ENCODE, S_THRESH, S_CLASSIFY} state_t;

    function automatic logic [D-1:0] rotl(input logic [D-1:0] v, input int s);
        logic [2*D-1:0] t;
        t = {v, v} << s;
        return t[2*D-1:D];
    endfunction

    function automatic logic [D-1:0] im(input logic [CHAR_W-1:0] c);
        return rotl(BASE_HV, int'(c) % D);
    endfunction

    function automatic logic [7:0] clamp(input logic [7:0] len_v);
        return (len_v > 8'(MSG_LEN)) ? 8'(MSG_LEN) : len_v;
    endfunction

    function automatic logic [CW-1:0] popcount(input logic [D-1:0] v);
        logic [CW-1:0] pc;
        pc = '0;
        for (int k = 0; k < D; k++) pc = pc + CW'(v[k]);
        return pc;
    endfunction

    state_t                      r_state, w_next;
    logic [MSG_LEN*CHAR_W-1:0]   r_msg;
    logic [7:0]                  r_len;
    logic                        r_stale;
    logic [7:0]                  r_idx;
    logic [D-1:0][7:0]           r_cnt;
    logic [D-1:0]                r_enc;
    logic [1:0]                  r_result;
    logic                        r_valid;

    logic [CHAR_W-1:0]           w_chars [MSG_LEN];
    logic [7:0]                  w_in_len, w_len, w_i1, w_i2;
    logic                        w_start, w_last;
    logic [D-1:0]                w_g, w_enc;
    logic [8:0]                  w_lm2;
    logic [CW-1:0]               w_dh, w_ds;
    logic [1:0]                  w_res;
    logic                        w_unused_label;

    // Encoding always reads the snapshot, so input changes mid-run are ignored.
    for (genvar gi = 0; gi < MSG_LEN; gi++) begin : g_chars
        assign w_chars[gi] = r_msg[MSG_LEN*CHAR_W-1-CHAR_W*gi -: CHAR_W];
    end

    assign w_unused_label = ^label;
    assign w_in_len = clamp(length);
    assign w_len    = clamp(r_len);
    assign w_start  = r_stale || (msg != r_msg) || (length != r_len);
    assign w_i1     = r_idx + 8'd1;
    assign w_i2     = r_idx + 8'd2;
    assign w_last   = (r_idx == w_len - 8'd3);
    assign w_g      = rotl(im(w_chars[r_idx]), 2) ^ rotl(im(w_chars[w_i1]), 1) ^ im(w_chars[w_i2]);
    assign w_lm2    = {1'b0, w_len} - 9'd2;
    assign w_dh     = popcount(r_enc ^ HAM_HV);
    assign w_ds     = popcount(r_enc ^ SPAM_HV);
    assign w_res    = (w_dh < w_ds) ? 2'b00 : (w_ds < w_dh) ? 2'b01 : 2'b11;

    // Majority: strictly more than half of the L-2 trigrams; ties fall to 0.
    always_comb begin
        w_enc = '0;
        for (int k = 0; k < D; k++) w_enc[k] = ({r_cnt[k], 1'b0} > w_lm2);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_start && w_in_len >= 8'd3) w_next = S_LOAD;
            S_LOAD:     w_next = S_ENCODE;
            S_ENCODE:   if (w_last) w_next = S_THRESH;
            S_THRESH:   w_next = S_CLASSIFY;
            S_CLASSIFY: w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_msg    <= '0;
            r_len    <= '0;
            r_stale  <= 1'b1;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_enc    <= '0;
            r_result <= 2'b11;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (w_start) begin
                    r_msg   <= msg;
                    r_len   <= length;
                    r_stale <= 1'b0;
                    if (w_in_len < 8'd3) begin
                        r_result <= 2'b11;
                        r_valid  <= 1'b1;
                    end else begin
                        r_valid  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    r_cnt <= '0;
                    r_idx <= '0;
                end
                S_ENCODE: begin
                    for (int k = 0; k < D; k++) r_cnt[k] <= r_cnt[k] + {7'd0, w_g[k]};
                    r_idx <= r_idx + 8'd1;
                end
                S_THRESH: r_enc <= w_enc;
                S_CLASSIFY: begin
                    r_result <= w_res;
                    r_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign result = r_result;
    assign valid  = r_valid;
endmodule

// File: tb/tb_hdc_main.sv
// Bench for hdc_main: table vectors, random messages against a spec-level
// model, plus reset-abort and mid-computation input-change sequences.
module tb_hdc_main;
    localparam int ML = 200;
    localparam int MW = ML * 8;

    function automatic logic [255:0] trot(input logic [255:0] v, input int s);
        logic [255:0] r;
        for (int k = 0; k < 256; k++) r[(k + s) % 256] = v[k];
        return r;
    endfunction

    localparam logic [255:0] BASE   = {8{32'hA5C3_9E17}};
    localparam logic [255:0] XV     = trot(BASE, 97);
    localparam logic [255:0] UNI_HV = trot(XV, 2) ^ trot(XV, 1) ^ XV;
    localparam logic [255:0] ZEROS  = '0;
    localparam logic [255:0] ONES   = '1;

    function automatic int tchar(input logic [MW-1:0] m, input int i);
        return int'(m[MW-1-8*i -: 8]);
    endfunction

    function automatic logic [1:0] model(input logic [MW-1:0] m, input int len,
                                         input logic [255:0] ham, input logic [255:0] spam);
        int L;
        int cnt [256];
        logic [255:0] g, enc;
        int dh, ds;
        L = (len > ML) ? ML : len;
        if (L < 3) return 2'b11;
        foreach (cnt[k]) cnt[k] = 0;
        for (int i = 0; i <= L - 3; i++) begin
            g = trot(trot(BASE, tchar(m, i)), 2) ^ trot(trot(BASE, tchar(m, i + 1)), 1)
              ^ trot(BASE, tchar(m, i + 2));
            for (int k = 0; k < 256; k++) cnt[k] += int'(g[k]);
        end
        for (int k = 0; k < 256; k++) enc[k] = (2 * cnt[k] > L - 2);
        dh = $countones(enc ^ ham);
        ds = $countones(enc ^ spam);
        if (dh < ds) return 2'b00;
        if (ds < dh) return 2'b01;
        return 2'b11;
    endfunction

    function automatic logic [MW-1:0] rmsg();
        logic [MW-1:0] r;
        for (int i = 0; i < MW / 32; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        logic [MW-1:0] m;
        logic [7:0]    len;
        logic [1:0]    em, eu, es, et;
        int            lat;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [MW-1:0] msg;
    logic [7:0]    length;
    logic [1:0]    label;
    logic [1:0]    res_m, res_u, res_s, res_t;
    logic          v_m, v_u, v_s, v_t;
    int            total = 0;
    int            bad = 0;

    always #5 clk = ~clk;

    hdc_main u_dut (.clk(clk), .reset(reset), .msg(msg), .length(length), .label(label),
                    .result(res_m), .valid(v_m));
    hdc_main #(.HAM_HV(UNI_HV), .SPAM_HV(~UNI_HV)) u_uni (.clk(clk), .reset(reset),
                    .msg(msg), .length(length), .label(label), .result(res_u), .valid(v_u));
    hdc_main #(.HAM_HV(~UNI_HV), .SPAM_HV(UNI_HV)) u_uni2 (.clk(clk), .reset(reset),
                    .msg(msg), .length(length), .label(label), .result(res_s), .valid(v_s));
    hdc_main #(.HAM_HV(UNI_HV), .SPAM_HV(UNI_HV)) u_tie (.clk(clk), .reset(reset),
                    .msg(msg), .length(length), .label(label), .result(res_t), .valid(v_t));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [MW-1:0] m, input logic [7:0] len);
        @(negedge clk);
        msg    = m;
        length = len;
        label  = 2'($urandom);
    endtask

    // Counts rising edges until valid is seen high; label is scrambled meanwhile.
    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (cyc < budget) begin
            @(posedge clk);
            #1;
            cyc++;
            label = 2'($urandom);
            if (v_m === 1'b1) break;
        end
    endtask

    task automatic check_vec(input string tag, input vec_t v);
        int cyc;
        apply(v.m, v.len);
        wait_valid(v.lat + 20, cyc);
        check({tag, "_lat"}, cyc, v.lat);
        check({tag, "_ham0"}, res_m, v.em);
        check({tag, "_uni"}, res_u, v.eu);
        check({tag, "_uni2"}, res_s, v.es);
        check({tag, "_tie"}, res_t, v.et);
        check({tag, "_vld"}, {v_u, v_s, v_t}, 3'b111);
    endtask

    function automatic vec_t mk(input logic [MW-1:0] m, input int len);
        vec_t v;
        int L;
        L     = (len > ML) ? ML : len;
        v.m   = m;
        v.len = 8'(len);
        v.em  = model(m, len, ZEROS, ONES);
        v.eu  = model(m, len, UNI_HV, ~UNI_HV);
        v.es  = model(m, len, ~UNI_HV, UNI_HV);
        v.et  = model(m, len, UNI_HV, UNI_HV);
        v.lat = (L < 3) ? 1 : L + 2;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t          tbl [$];
        vec_t          v;
        logic [MW-1:0] uni, ma, mb;
        logic [1:0]    ea, eb;
        int            cyc, len;

        uni = {ML{8'h61}};
        v = mk(uni, 200); v.eu = 2'b00; v.es = 2'b01; v.et = 2'b11; v.lat = 202;
        tbl.push_back(v);
        tbl.push_back(mk(rmsg(), 2));
        tbl.push_back(mk(rmsg(), 0));
        tbl.push_back(mk(rmsg(), 3));
        v.len = 8'd255; tbl.push_back(v);
        tbl.push_back(mk(rmsg(), 4));
        tbl.push_back(mk(rmsg(), 200));
        v.len = 8'd201; tbl.push_back(v);

        reset = 1'b1; msg = '0; length = '0; label = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result", res_m, 2'b11);
        check("rst_valid", v_m, 1'b0);
        check("rst_result_uni", res_u, 2'b11);
        @(negedge clk) reset = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_short", {v_m, res_m}, 3'b111);

        foreach (tbl[i]) check_vec($sformatf("tbl%0d", i), tbl[i]);

        for (int n = 0; n < 8; n++) begin
            len = $urandom_range(0, 255);
            check_vec($sformatf("rnd%0d", n), mk(rmsg(), len));
        end

        // Reset while encoding aborts immediately, then reclassifies.
        check_vec("pre_rst", tbl[0]);
        ma = rmsg();
        apply(ma, 8'd50);
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy_valid", v_m, 1'b0);
        check("mid_busy_hold", res_u, 2'b00);
        @(negedge clk) reset = 1'b1;
        #1;
        check("abort_result", res_m, 2'b11);
        check("abort_valid", v_m, 1'b0);
        check("abort_uni", res_u, 2'b11);
        check("abort_uni2", res_s, 2'b11);
        @(negedge clk) reset = 1'b0;
        wait_valid(80, cyc);
        check("rerun_lat", cyc, 52);
        check("rerun_res", res_m, model(ma, 50, ZEROS, ONES));
        check("rerun_uni", res_u, model(ma, 50, UNI_HV, ~UNI_HV));

        // Input change during ENCODE: old message finishes first, then the new one.
        ma = rmsg();
        ea = model(ma, 30, ZEROS, ONES);
        mb = rmsg();
        eb = model(mb, 40, ZEROS, ONES);
        for (int t = 0; t < 64 && eb == ea; t++) begin
            mb = rmsg();
            eb = model(mb, 40, ZEROS, ONES);
        end
        apply(ma, 8'd30);
        cyc = 0;
        while (cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
            label = 2'($urandom);
            if (v_m === 1'b1) break;
            if (cyc == 6) begin
                msg    = mb;
                length = 8'd40;
            end
        end
        check("chg_old_lat", cyc, 32);
        check("chg_old_res", res_m, ea);
        @(posedge clk);
        #1;
        check("chg_valid_drop", v_m, 1'b0);
        wait_valid(80, cyc);
        check("chg_new_lat", cyc, 41);
        check("chg_new_res", res_m, eb);
        check("chg_new_uni", res_u, model(mb, 40, UNI_HV, ~UNI_HV));
        check("chg_new_tie", res_t, 2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
